// File: rtl/adder_pkg.sv
// Constants and helpers shared by the adder family: default operand/segment
// widths and the pipeline stage count derived from them.
package adder_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_SEG   = 4;

    // Illegal splits collapse to one stage so the parameter check in the
    // instantiating module is what reports the error, not a zero-width array.
    function automatic int stage_count(input int width, input int seg);
        if (seg < 1 || width < seg) return 1;
        return width / seg;
    endfunction

endpackage

// File: rtl/rca_segment.sv
// Combinational W-bit ripple-carry chain of full adders; one segment of the
// pipelined adder.
module rca_segment #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    logic [W:0] c;

    always_comb begin
        s    = '0;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < W; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign co = c[W];

endmodule

// File: rtl/pipelined_rca_adder.sv
// WIDTH-bit ripple-carry adder split into SEG-bit pipeline stages with a
// valid/ready handshake on both sides; one result per cycle, FIFO ordered.
module pipelined_rca_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEG   = DEF_SEG
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    localparam int NSTAGES = stage_count(WIDTH, SEG);

    if (WIDTH < 1 || SEG < 1 || (WIDTH % SEG) != 0) begin : g_param_chk
        $error("pipelined_rca_adder: WIDTH=%0d must be a positive multiple of SEG=%0d", WIDTH, SEG);
    end

    logic [NSTAGES-1:0] vld_q, vld_d;
    logic [NSTAGES-1:0] vld_in;
    logic [NSTAGES-1:0] adv;
    logic [NSTAGES:0]   rdy;

    // A stage can take new data if it is empty or its occupant moves on this cycle.
    always_comb begin
        rdy[NSTAGES] = out_ready;
        for (int k = NSTAGES - 1; k >= 0; k--) begin
            rdy[k] = !vld_q[k] || rdy[k+1];
        end
        vld_in[0] = in_valid;
        for (int k = 1; k < NSTAGES; k++) begin
            vld_in[k] = vld_q[k-1];
        end
        for (int k = 0; k < NSTAGES; k++) begin
            vld_d[k] = rdy[k] ? vld_in[k] : vld_q[k];
            adv[k]   = rdy[k] && vld_in[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_q <= '0;
        else        vld_q <= vld_d;
    end

    for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
        localparam int SUM_W = (k + 1) * SEG;
        localparam int HI_W  = WIDTH - SUM_W;

        logic [SEG-1:0]   seg_a, seg_b, seg_s;
        logic             seg_ci, seg_co;
        logic [SUM_W-1:0] sum_d, sum_q;
        logic             co_d, co_q;

        if (k == 0) begin : g_src
            always_comb begin
                seg_a  = a[SEG-1:0];
                seg_b  = b[SEG-1:0];
                seg_ci = cin;
            end
            always_comb begin
                sum_d = seg_s;
                co_d  = seg_co;
            end
        end else begin : g_src
            // Slice k is the low end of what the previous stage still carries.
            always_comb begin
                seg_a  = g_stage[k-1].g_skew.a_hi_q[SEG-1:0];
                seg_b  = g_stage[k-1].g_skew.b_hi_q[SEG-1:0];
                seg_ci = g_stage[k-1].co_q;
            end
            always_comb begin
                sum_d = {seg_s, g_stage[k-1].sum_q};
                co_d  = seg_co;
            end
        end

        rca_segment #(.W(SEG)) u_seg (
            .a  (seg_a),
            .b  (seg_b),
            .ci (seg_ci),
            .s  (seg_s),
            .co (seg_co)
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_q <= '0;
                co_q  <= 1'b0;
            end else if (adv[k]) begin
                sum_q <= sum_d;
                co_q  <= co_d;
            end
        end

        if (HI_W > 0) begin : g_skew
            logic [HI_W-1:0] a_hi_d, b_hi_d, a_hi_q, b_hi_q;

            if (k == 0) begin : g_src
                always_comb begin
                    a_hi_d = a[WIDTH-1:SEG];
                    b_hi_d = b[WIDTH-1:SEG];
                end
            end else begin : g_src
                always_comb begin
                    a_hi_d = g_stage[k-1].g_skew.a_hi_q[SEG +: HI_W];
                    b_hi_d = g_stage[k-1].g_skew.b_hi_q[SEG +: HI_W];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_hi_q <= '0;
                    b_hi_q <= '0;
                end else if (adv[k]) begin
                    a_hi_q <= a_hi_d;
                    b_hi_q <= b_hi_d;
                end
            end
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = vld_q[NSTAGES-1];
    assign s         = g_stage[NSTAGES-1].sum_q;
    assign cout      = g_stage[NSTAGES-1].co_q;

endmodule

// File: tb/tb_pipelined_rca_adder.sv
// Randomised bench for pipelined_rca_adder: three configurations (8/4, 16/16,
// 32/8) scored against an arithmetic reference model with FIFO queues.
module tb_pipelined_rca_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        iv_src, or_src, cin_src;
    logic [31:0] a_src, b_src;
    int          sel;

    logic        iv0, ir0, ov0, co0;
    logic [7:0]  s0;
    logic        iv1, ir1, ov1, co1;
    logic [15:0] s1;
    logic        iv2, ir2, ov2, co2;
    logic [31:0] s2;

    assign iv0 = iv_src && (sel == 0);
    assign iv1 = iv_src && (sel == 1);
    assign iv2 = iv_src && (sel == 2);

    pipelined_rca_adder #(.WIDTH(8), .SEG(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0),
        .a(a_src[7:0]), .b(b_src[7:0]), .cin(cin_src),
        .out_valid(ov0), .out_ready(or_src), .s(s0), .cout(co0));

    pipelined_rca_adder #(.WIDTH(16), .SEG(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
        .a(a_src[15:0]), .b(b_src[15:0]), .cin(cin_src),
        .out_valid(ov1), .out_ready(or_src), .s(s1), .cout(co1));

    pipelined_rca_adder #(.WIDTH(32), .SEG(8)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2),
        .a(a_src), .b(b_src), .cin(cin_src),
        .out_valid(ov2), .out_ready(or_src), .s(s2), .cout(co2));

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [63:0] q0[$], q1[$], q2[$];
    int          oc0[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain (w+1)-bit addition, packed as {cout at bit 32, sum}.
    function automatic logic [63:0] ref_sum(input logic [31:0] a, input logic [31:0] b,
                                            input logic c, input int w);
        logic [63:0] m, t;
        m = (64'd1 << w) - 64'd1;
        t = (64'(a) & m) + (64'(b) & m) + 64'(c);
        return (((t >> w) & 64'd1) << 32) | (t & m);
    endfunction

    function automatic logic rdy_of(input int d);
        case (d)
            0:       return ir0;
            1:       return ir1;
            default: return ir2;
        endcase
    endfunction

    function automatic logic ov_of(input int d);
        case (d)
            0:       return ov0;
            1:       return ov1;
            default: return ov2;
        endcase
    endfunction

    function automatic logic [63:0] obs_of(input int d);
        case (d)
            0:       return {31'b0, co0, 24'b0, s0};
            1:       return {31'b0, co1, 16'b0, s1};
            default: return {31'b0, co2, s2};
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Inputs only change just after a rising edge, so the negedge view is
    // exactly what the next rising edge will act on.
    always @(negedge clk) begin
        if (rst_n) begin
            if (iv0 && ir0) q0.push_back(ref_sum(a_src, b_src, cin_src, 8));
            if (iv1 && ir1) q1.push_back(ref_sum(a_src, b_src, cin_src, 16));
            if (iv2 && ir2) q2.push_back(ref_sum(a_src, b_src, cin_src, 32));
            if (ov0 && or_src) begin
                oc0.push_back(cyc);
                if (q0.size() == 0) chk("d8_spurious_out", 64'(ov0), 64'd0);
                else                chk("d8_result", obs_of(0), q0.pop_front());
            end
            if (ov1 && or_src) begin
                if (q1.size() == 0) chk("d16_spurious_out", 64'(ov1), 64'd0);
                else                chk("d16_result", obs_of(1), q1.pop_front());
            end
            if (ov2 && or_src) begin
                if (q2.size() == 0) chk("d32_spurious_out", 64'(ov2), 64'd0);
                else                chk("d32_result", obs_of(2), q2.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d, input logic [31:0] a, input logic [31:0] b, input logic c);
        logic acc;
        int   guard;
        sel = d; a_src = a; b_src = b; cin_src = c; iv_src = 1'b1;
        acc = 1'b0;
        guard = 0;
        while (!acc) begin
            @(negedge clk);
            acc = rdy_of(d);
            tick();
            guard++;
            if (!acc && guard > 200) begin
                chk("accept_timeout", 64'(acc), 64'd1);
                break;
            end
        end
        iv_src = 1'b0;
    endtask

    task automatic lat_test(input string tag, input int d, input logic [31:0] a, input logic [31:0] b,
                            input logic c, input int exp_lat, input logic [63:0] exp_val);
        int lat;
        or_src = 1'b1;
        send(d, a, b, c);
        for (lat = 0; lat < 50; lat++) begin
            @(negedge clk);
            if (ov_of(d)) break;
            tick();
        end
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_val"}, obs_of(d), exp_val);
        tick();
    endtask

    task automatic rand_stream(input int d, input int n);
        bit done;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < n; i++) send(d, $urandom, $urandom, 1'($urandom));
                done = 1'b1;
            end
            begin
                while (!done) begin
                    or_src = ($urandom_range(0, 3) != 0);
                    tick();
                end
            end
        join
        or_src = 1'b1;
        repeat (12) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycles=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] hold;
        rst_n = 1'b0; iv_src = 1'b0; or_src = 1'b1; cin_src = 1'b0;
        a_src = '0; b_src = '0; sel = 0;
        repeat (3) tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", {ov2, ov1, ov0}, 64'd0);
        chk("rst_d8_sum", obs_of(0), 64'd0);
        chk("rst_d32_sum", obs_of(2), 64'd0);
        chk("rst_in_ready", {ir2, ir1, ir0}, 64'h7);
        tick();

        // Directed: latency counted in edges after the accepting edge.
        lat_test("d8_1p0",   0, 32'h01, 32'h00, 1'b0, 1, 64'h1);
        lat_test("d8_1p1c",  0, 32'h01, 32'h01, 1'b1, 1, 64'h3);
        lat_test("d8_ffp1",  0, 32'hFF, 32'h01, 1'b0, 1, 64'h1_0000_0000);
        lat_test("d16_max",  1, 32'hFFFF, 32'h0001, 1'b1, 0, 64'h1_0000_0001);
        lat_test("d32_ripple", 2, 32'hFFFF_FFFF, 32'h0, 1'b1, 3, 64'h1_0000_0000);
        lat_test("d32_mid",  2, 32'h00FF_FF00, 32'h0000_0100, 1'b0, 3, 64'h0100_0000);

        // Back-to-back stream with no backpressure: outputs on consecutive cycles.
        oc0.delete();
        or_src = 1'b1;
        for (int i = 0; i < 16; i++) send(0, $urandom, $urandom, 1'($urandom));
        repeat (6) tick();
        chk("d8_stream_cnt", 64'(oc0.size()), 64'd16);
        chk("d8_stream_span", (oc0.size() == 16) ? 64'(oc0[15] - oc0[0]) : 64'hDEAD, 64'd15);

        // Backpressure: two stages fill, then in_ready drops and outputs hold.
        or_src = 1'b0;
        send(0, 32'h5A, 32'hA7, 1'b1);
        send(0, 32'h33, 32'h44, 1'b0);
        @(negedge clk);
        chk("d8_full_in_ready", 64'(ir0), 64'd0);
        chk("d8_full_out_valid", 64'(ov0), 64'd1);
        hold = obs_of(0);
        chk("d8_hold_val", hold, ref_sum(32'h5A, 32'hA7, 1'b1, 8));
        repeat (3) @(negedge clk);
        chk("d8_hold_stable", obs_of(0), hold);
        chk("d8_hold_valid", 64'(ov0), 64'd1);
        tick();
        fork
            begin
                send(0, 32'h80, 32'h80, 1'b1);
                send(0, 32'h0F, 32'hF0, 1'b1);
            end
            begin
                repeat (3) tick();
                or_src = 1'b1;
            end
        join
        repeat (6) tick();
        chk("d8_drain_empty", 64'(q0.size()), 64'd0);

        rand_stream(1, 12);
        chk("d16_rand_empty", 64'(q1.size()), 64'd0);
        rand_stream(2, 40);
        chk("d32_rand_empty", 64'(q2.size()), 64'd0);
        rand_stream(0, 30);
        chk("d8_rand_empty", 64'(q0.size()), 64'd0);

        // Reset with two operations in flight: everything flushed at once.
        or_src = 1'b0;
        send(0, 32'h35, 32'h42, 1'b0);
        send(0, 32'h11, 32'h22, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 64'(ov0), 64'd0);
        chk("rst_mid_sum", obs_of(0), 64'd0);
        q0.delete(); q1.delete(); q2.delete();
        tick();
        rst_n = 1'b1;
        or_src = 1'b1;
        repeat (6) tick();
        @(negedge clk);
        chk("rst_post_valid", 64'(ov0), 64'd0);
        chk("rst_post_in_ready", 64'(ir0), 64'd1);
        tick();
        lat_test("d8_post_rst", 0, 32'hC3, 32'h3C, 1'b1, 1, 64'h1_0000_0000);

        chk("final_q_empty", 64'(q0.size() + q1.size() + q2.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
